apb_req_master: RTL and testbench

//  Single-outstanding APB4 requester: converts a valid/ready command stream into
//  APB SETUP/ACCESS transfers and returns a response stream. Sits directly upstream
//  of any APB completer (e.g. our demo APB memory slave), driving its PSEL/PENABLE bus.

---
 rtl/apb_req_master_pkg.sv | 19 +
 rtl/apb_req_master_if.sv | 52 +++++
 rtl/apb_req_master.sv | 150 +++++++++++++++
 tb/tb_apb_req_master.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_req_master_pkg.sv
// Shared types and helpers for the single-outstanding APB4 requester.
package apb_req_master_pkg;

    // Requester FSM: one command walks IDLE -> SETUP -> ACCESS -> RESP.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam int PPROT_W = 3;

    // Width of a counter that must hold values 0 .. limit-1.
    function automatic int tmo_cnt_w(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/apb_req_master_if.sv
// Command/response stream plus APB4 bus, bundled for the requester.
interface apb_req_master_if #(
    parameter int AW = 12,
    parameter int DW = 32
) ();
    import apb_req_master_pkg::*;

    // command stream
    logic                 i_valid;
    logic                 o_ready;
    logic                 i_we;
    logic [AW-1:0]        i_addr;
    logic [DW-1:0]        i_data;
    logic [DW/8-1:0]      i_strb;
    logic [PPROT_W-1:0]   i_prot;

    // response stream
    logic                 o_rvalid;
    logic                 i_rready;
    logic [DW-1:0]        o_rdata;
    logic                 o_err;
    logic                 o_tmo;

    // APB4 bus
    logic                 PSEL;
    logic                 PENABLE;
    logic [AW-1:0]        PADDR;
    logic                 PWRITE;
    logic [DW-1:0]        PWDATA;
    logic [DW/8-1:0]      PWSTRB;
    logic [PPROT_W-1:0]   PPROT;
    logic                 PREADY;
    logic [DW-1:0]        PRDATA;
    logic                 PSLVERR;

    // The requester itself.
    modport master (
        input  i_valid, i_we, i_addr, i_data, i_strb, i_prot, i_rready,
        input  PREADY, PRDATA, PSLVERR,
        output o_ready, o_rvalid, o_rdata, o_err, o_tmo,
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PWSTRB, PPROT
    );

    // Whatever sits around it: command source, response sink and completer.
    modport slave (
        output i_valid, i_we, i_addr, i_data, i_strb, i_prot, i_rready,
        output PREADY, PRDATA, PSLVERR,
        input  o_ready, o_rvalid, o_rdata, o_err, o_tmo,
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PWSTRB, PPROT
    );

endinterface

// File: rtl/apb_req_master.sv
// Single-outstanding APB4 requester: turns one accepted command into one
// SETUP/ACCESS transfer and returns one response, with an optional PREADY
// timeout so a hung completer cannot stall the command stream.
module apb_req_master
    import apb_req_master_pkg::*;
#(
    parameter int C_APB_ADDR_WIDTH = 12,
    parameter int C_APB_DATA_WIDTH = 32,
    parameter int OPT_TIMEOUT      = 0
) (
    input  logic             PCLK,
    input  logic             PRESET,
    apb_req_master_if.master bus
);

    localparam int AW = C_APB_ADDR_WIDTH;
    localparam int DW = C_APB_DATA_WIDTH;
    localparam int SW = DW / 8;

    state_t state;
    state_t state_nxt;
    logic   ready_nxt;
    logic   psel_nxt;
    logic   penable_nxt;
    logic   rvalid_nxt;
    logic   load_cmd;
    logic   done_ok;
    logic   tmo_hit;

    // State register; reset may land in any state, including mid-ACCESS.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the next values of the registered control outputs.
    always_comb begin
        state_nxt   = state;
        load_cmd    = 1'b0;
        done_ok     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.i_valid && bus.o_ready) begin
                    load_cmd  = 1'b1;
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A completion in the same cycle as the limit takes priority.
                if (bus.PREADY) begin
                    done_ok   = 1'b1;
                    state_nxt = ST_RESP;
                end else if (tmo_hit) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.i_rready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        ready_nxt   = (state_nxt == ST_IDLE);
        psel_nxt    = (state_nxt == ST_SETUP) || (state_nxt == ST_ACCESS);
        penable_nxt = (state_nxt == ST_ACCESS);
        rvalid_nxt  = (state_nxt == ST_RESP);
    end

    // Control outputs are flops so the APB bus and handshakes are glitch-free.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            bus.o_ready  <= 1'b1;
            bus.PSEL     <= 1'b0;
            bus.PENABLE  <= 1'b0;
            bus.o_rvalid <= 1'b0;
        end else begin
            bus.o_ready  <= ready_nxt;
            bus.PSEL     <= psel_nxt;
            bus.PENABLE  <= penable_nxt;
            bus.o_rvalid <= rvalid_nxt;
        end
    end

    // Command latch (held through the transfer and afterwards) and response capture.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            bus.PADDR   <= '0;
            bus.PWRITE  <= 1'b0;
            bus.PWDATA  <= '0;
            bus.PWSTRB  <= '0;
            bus.PPROT   <= '0;
            bus.o_rdata <= '0;
            bus.o_err   <= 1'b0;
            bus.o_tmo   <= 1'b0;
        end else begin
            if (load_cmd) begin
                bus.PADDR  <= bus.i_addr;
                bus.PWRITE <= bus.i_we;
                bus.PWDATA <= bus.i_data;
                bus.PPROT  <= bus.i_prot;
                // Reads drive all-zero strobes on the bus.
                bus.PWSTRB <= bus.i_we ? bus.i_strb : {SW{1'b0}};
            end
            if (done_ok) begin
                if (!bus.PWRITE) begin
                    bus.o_rdata <= bus.PRDATA;
                end
                bus.o_err <= bus.PSLVERR;
                bus.o_tmo <= 1'b0;
            end else if (tmo_hit) begin
                bus.o_err <= 1'b1;
                bus.o_tmo <= 1'b1;
            end
        end
    end

    generate
        if (OPT_TIMEOUT > 0) begin : g_tmo
            localparam int            CW    = tmo_cnt_w(OPT_TIMEOUT);
            localparam logic [CW-1:0] LIMIT = CW'(OPT_TIMEOUT - 1);

            logic [CW-1:0] tmo_cnt;

            // Counts stalled ACCESS cycles; cleared in SETUP, saturates at the limit.
            always_ff @(posedge PCLK or posedge PRESET) begin
                if (PRESET) begin
                    tmo_cnt <= '0;
                end else if (state == ST_SETUP) begin
                    tmo_cnt <= '0;
                end else if ((state == ST_ACCESS) && !bus.PREADY && (tmo_cnt != LIMIT)) begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end

            assign tmo_hit = (state == ST_ACCESS) && !bus.PREADY && (tmo_cnt == LIMIT);
        end else begin : g_no_tmo
            assign tmo_hit = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_apb_req_master.sv
// Randomised bench for apb_req_master: a behavioural memory completer on the
// APB side, a reference model that predicts each response at issue time, and
// a monitor that checks the bus and pops expected responses.
module tb_apb_req_master;

    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic PCLK   = 1'b0;
    logic PRESET = 1'b1;

    always #5 PCLK = ~PCLK;

    apb_req_master_if #(.AW(AW), .DW(DW)) bus ();

    apb_req_master #(
        .C_APB_ADDR_WIDTH(AW),
        .C_APB_DATA_WIDTH(DW),
        .OPT_TIMEOUT     (TMO)
    ) dut (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        int          lat;
        int          pen;
    } rsp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [31:0]   wdata;
        logic [3:0]    strb;
        logic [2:0]    prot;
    } apb_t;

    typedef struct {
        int   wait_c;
        logic err;
    } beh_t;

    rsp_t rsp_q[$];
    apb_t apb_q[$];
    beh_t beh_q[$];

    logic [31:0] ref_mem [1024];
    logic [31:0] ref_last;
    logic [31:0] slv_mem [1024];
    int          rready_delay;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Behavioural completer: PREADY after wait_c stalled ACCESS cycles; erroring writes are dropped.
    int   s_cnt;
    beh_t s_beh;
    always begin
        @(posedge PCLK);
        #1;
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        bus.PRDATA  = $urandom();
        if (!PRESET && bus.PSEL && !bus.PENABLE) begin
            if (beh_q.size() > 0) s_beh = beh_q.pop_front();
            else s_beh = '{0, 1'b0};
            s_cnt = 0;
        end else if (!PRESET && bus.PSEL && bus.PENABLE) begin
            if (s_cnt == s_beh.wait_c) begin
                bus.PREADY  = 1'b1;
                bus.PSLVERR = s_beh.err;
                bus.PRDATA  = slv_mem[bus.PADDR[11:2]];
                if (bus.PWRITE && !s_beh.err) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.PWSTRB[b]) slv_mem[bus.PADDR[11:2]][8*b +: 8] = bus.PWDATA[8*b +: 8];
                end
            end
            s_cnt++;
        end
    end

    // Response sink: take each response after rready_delay cycles of o_rvalid.
    int rcnt = 0;
    always begin
        @(posedge PCLK);
        #1;
        if (bus.o_rvalid) begin
            bus.i_rready = (rcnt >= rready_delay);
            rcnt++;
        end else begin
            bus.i_rready = 1'b0;
            rcnt = 0;
        end
    end

    // Monitor: APB ordering and stability, response values, latency and hold behaviour.
    int          cyc = 0;
    int          acc_cyc = 0;
    int          pen_cnt = 0;
    logic        in_rsp = 1'b0;
    logic        ready_chk = 1'b0;
    apb_t        cur;
    rsp_t        exp_r;
    logic [31:0] h_rdata;
    logic        h_err, h_tmo;
    always @(negedge PCLK) begin
        cyc++;
        if (PRESET) begin
            in_rsp    = 1'b0;
            ready_chk = 1'b0;
            pen_cnt   = 0;
        end else begin
            if (ready_chk) begin
                check("o_ready after response handshake", 32'(bus.o_ready), 32'd1);
                ready_chk = 1'b0;
            end
            if (bus.PENABLE) check("PENABLE implies PSEL", 32'(bus.PSEL), 32'd1);
            if (bus.o_ready) check("o_ready implies no PSEL", 32'(bus.PSEL), 32'd0);
            if (bus.i_valid && bus.o_ready) acc_cyc = cyc;
            if (bus.PSEL && !bus.PENABLE) begin
                if (apb_q.size() == 0) begin
                    fail_now("unexpected SETUP phase");
                end else begin
                    cur = apb_q.pop_front();
                    check("SETUP PADDR", 32'(bus.PADDR), 32'(cur.addr));
                    check("SETUP PWRITE", 32'(bus.PWRITE), 32'(cur.we));
                    check("SETUP PWDATA", bus.PWDATA, cur.wdata);
                    check("SETUP PWSTRB", 32'(bus.PWSTRB), 32'(cur.strb));
                    check("SETUP PPROT", 32'(bus.PPROT), 32'(cur.prot));
                end
                pen_cnt = 0;
            end
            if (bus.PSEL && bus.PENABLE) begin
                pen_cnt++;
                check("ACCESS PADDR stable", 32'(bus.PADDR), 32'(cur.addr));
                check("ACCESS PWDATA stable", bus.PWDATA, cur.wdata);
            end
            if (bus.o_rvalid && !in_rsp) begin
                in_rsp = 1'b1;
                h_rdata = bus.o_rdata;
                h_err   = bus.o_err;
                h_tmo   = bus.o_tmo;
                if (rsp_q.size() == 0) begin
                    fail_now("unexpected response");
                end else begin
                    exp_r = rsp_q.pop_front();
                    check("o_rdata", bus.o_rdata, exp_r.rdata);
                    check("o_err", 32'(bus.o_err), 32'(exp_r.err));
                    check("o_tmo", 32'(bus.o_tmo), 32'(exp_r.tmo));
                    check("response latency", 32'(cyc - acc_cyc), 32'(exp_r.lat));
                    check("PENABLE cycles", 32'(pen_cnt), 32'(exp_r.pen));
                end
            end else if (bus.o_rvalid) begin
                check("held o_rdata", bus.o_rdata, h_rdata);
                check("held o_err", 32'(bus.o_err), 32'(h_err));
                check("held o_tmo", 32'(bus.o_tmo), 32'(h_tmo));
                check("o_ready low while response pending", 32'(bus.o_ready), 32'd0);
                check("PSEL low while response pending", 32'(bus.PSEL), 32'd0);
            end
            if (bus.o_rvalid && bus.i_rready) begin
                in_rsp    = 1'b0;
                ready_chk = 1'b1;
            end
        end
    end

    // Predict the response from the command and completer behaviour, then issue the command.
    task automatic send(input logic we, input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] p,
                        input int w, input logic e, input int rd);
        rsp_t r;
        apb_t x;
        int   n;
        logic acc;
        x = '{a, we, d, (we ? s : 4'h0), p};
        if (w >= TMO) begin
            r = '{ref_last, 1'b1, 1'b1, TMO + 2, TMO};
        end else begin
            if (!we) begin
                ref_last = ref_mem[a[11:2]];
            end else if (!e) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) ref_mem[a[11:2]][8*b +: 8] = d[8*b +: 8];
            end
            r = '{ref_last, e, 1'b0, w + 3, w + 1};
        end
        apb_q.push_back(x);
        beh_q.push_back('{w, e});
        rsp_q.push_back(r);
        bus.i_valid = 1'b1;
        bus.i_we    = we;
        bus.i_addr  = a;
        bus.i_data  = d;
        bus.i_strb  = s;
        bus.i_prot  = p;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge PCLK);
            if (bus.o_ready) acc = 1'b1;
            @(posedge PCLK);
            #1;
            n++;
        end
        if (!acc) fail_now("command accept timeout");
        bus.i_valid  = 1'b0;
        rready_delay = rd;
    endtask

    // Directed scenarios, mid-transfer reset, random traffic, then drain.
    initial begin
        int n;
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = 32'h0;
            slv_mem[i] = 32'h0;
        end
        ref_last     = 32'h0;
        rready_delay = 0;
        bus.i_valid  = 1'b0;
        bus.i_we     = 1'b0;
        bus.i_addr   = '0;
        bus.i_data   = '0;
        bus.i_strb   = '0;
        bus.i_prot   = '0;
        bus.i_rready = 1'b0;
        bus.PREADY   = 1'b0;
        bus.PRDATA   = '0;
        bus.PSLVERR  = 1'b0;

        repeat (3) @(posedge PCLK);
        #3;
        PRESET = 1'b0;
        @(negedge PCLK);
        check("reset o_ready", 32'(bus.o_ready), 32'd1);
        check("reset PSEL", 32'(bus.PSEL), 32'd0);
        check("reset PENABLE", 32'(bus.PENABLE), 32'd0);
        check("reset o_rvalid", 32'(bus.o_rvalid), 32'd0);
        check("reset o_err", 32'(bus.o_err), 32'd0);
        check("reset o_tmo", 32'(bus.o_tmo), 32'd0);
        check("reset o_rdata", bus.o_rdata, 32'h0);
        check("reset PADDR", 32'(bus.PADDR), 32'h0);
        check("reset PWSTRB", 32'(bus.PWSTRB), 32'h0);
        @(posedge PCLK);
        #1;

        // write then read back, zero-wait
        send(1'b1, 12'h010, 32'h12345678, 4'hF, 3'd0, 0, 1'b0, 0);
        send(1'b0, 12'h010, 32'h0, 4'hF, 3'd1, 0, 1'b0, 0);
        // partial-strobe write over it
        send(1'b1, 12'h010, 32'hAABBCCDD, 4'h5, 3'd2, 0, 1'b0, 0);
        send(1'b0, 12'h010, 32'h0, 4'h0, 3'd0, 0, 1'b0, 0);
        // slow completer with error
        send(1'b1, 12'h024, 32'hCAFEF00D, 4'hF, 3'd2, 3, 1'b1, 0);
        send(1'b0, 12'h024, 32'h0, 4'h0, 3'd0, 0, 1'b0, 0);
        // PREADY on the last allowed cycle completes normally, then stuck PREADY times out
        send(1'b0, 12'h010, 32'h0, 4'h0, 3'd0, TMO - 1, 1'b0, 0);
        send(1'b0, 12'h010, 32'h0, 4'h0, 3'd5, 100, 1'b0, 0);
        send(1'b0, 12'h010, 32'h0, 4'h0, 3'd0, 0, 1'b0, 0);
        // slow response consumer, next command held valid
        send(1'b0, 12'h010, 32'h0, 4'h0, 3'd0, 0, 1'b0, 5);
        send(1'b1, 12'h030, 32'h0BADBEEF, 4'hA, 3'd7, 0, 1'b0, 0);
        send(1'b0, 12'h030, 32'h0, 4'h0, 3'd0, 1, 1'b0, 0);

        // reset while ACCESS is in progress
        send(1'b0, 12'h020, 32'h0, 4'h0, 3'd0, 50, 1'b0, 0);
        n = 0;
        while (!bus.PENABLE && n < 20) begin
            @(posedge PCLK);
            #1;
            n++;
        end
        if (!bus.PENABLE) fail_now("ACCESS never reached before reset");
        @(posedge PCLK);
        #3;
        PRESET = 1'b1;
        #1;
        check("async reset PSEL", 32'(bus.PSEL), 32'd0);
        check("async reset PENABLE", 32'(bus.PENABLE), 32'd0);
        check("async reset o_rvalid", 32'(bus.o_rvalid), 32'd0);
        check("async reset PADDR", 32'(bus.PADDR), 32'h0);
        rsp_q.delete();
        ref_last = 32'h0;
        repeat (2) @(posedge PCLK);
        #3;
        PRESET = 1'b0;
        @(negedge PCLK);
        check("o_ready after reset release", 32'(bus.o_ready), 32'd1);
        check("no response after reset", 32'(bus.o_rvalid), 32'd0);
        @(posedge PCLK);
        #1;
        send(1'b0, 12'h030, 32'h0, 4'h0, 3'd0, 0, 1'b0, 0);

        // random traffic
        for (int t = 0; t < 40; t++) begin
            int   w;
            logic we;
            case ($urandom_range(0, 7))
                0, 1, 2: w = 0;
                3:       w = 1;
                4:       w = 2;
                5:       w = TMO - 1;
                6:       w = 20;
                default: w = 3;
            endcase
            we = 1'($urandom_range(0, 1));
            send(we, 12'($urandom_range(0, 63)), $urandom(), 4'($urandom_range(0, 15)),
                 3'($urandom_range(0, 7)), w, ($urandom_range(0, 5) == 0), $urandom_range(0, 3));
        end

        n = 0;
        while ((rsp_q.size() != 0 || bus.o_rvalid) && n < 1000) begin
            @(posedge PCLK);
            #1;
            n++;
        end
        if (rsp_q.size() != 0) fail_now("responses still outstanding at end");
        repeat (2) @(posedge PCLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog expired: errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
